// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch-stage program counter with a bounded
// hardware return-address stack and sticky stack error flags.
// Optional build macro: PC_TRAP_EN. When it is defined, a call on a full
// stack or a ret on an empty stack also redirects the PC to TRAP_VECTOR.
module program_counter_stack #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = '1
) (
  input  logic                             clock,
  input  logic                             clear_n,
  input  logic                             enable,
  input  logic                             load,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [PC_WIDTH-1:0]              new_pc,
  input  logic [OFFSET_WIDTH-1:0]          offset,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             overflow_err,
  output logic                             underflow_err
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned INDEX_W = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] offset_ext;
  logic [INDEX_W-1:0]  push_idx;
  logic [INDEX_W-1:0]  pop_idx;

  logic [PC_WIDTH-1:0] pc_next;
  logic [DEPTH_W-1:0]  depth_next;
  logic                push_en;
  logic                ovf_set;
  logic                unf_set;

  assign stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (stack_depth == '0);

  // Return address and branch target both wrap modulo 2^PC_WIDTH.
  assign pc_inc     = pc_out + 1'b1;
  assign offset_ext = PC_WIDTH'(signed'(offset));

  // The depth counter indexes the array directly: the next free slot on a
  // push, the top entry on a pop. Both are only used when in range.
  assign push_idx = INDEX_W'(stack_depth);
  assign pop_idx  = INDEX_W'(stack_depth - 1'b1);

`ifndef PC_TRAP_EN
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  // Operation select with fixed priority call > ret > load > branch > increment.
  always_comb begin
    pc_next    = pc_out;
    depth_next = stack_depth;
    push_en    = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (enable) begin
      if (call) begin
        pc_next = new_pc;
        if (!stack_full) begin
          push_en    = 1'b1;
          depth_next = stack_depth + 1'b1;
        end else begin
          ovf_set = 1'b1;
`ifdef PC_TRAP_EN
          pc_next = TRAP_VECTOR;
`endif
        end
      end else if (ret) begin
        if (!stack_empty) begin
          pc_next    = stack_mem[pop_idx];
          depth_next = stack_depth - 1'b1;
        end else begin
          unf_set = 1'b1;
`ifdef PC_TRAP_EN
          pc_next = TRAP_VECTOR;
`else
          pc_next = pc_inc;
`endif
        end
      end else if (load) begin
        pc_next = new_pc;
      end else if (branch) begin
        pc_next = pc_out + offset_ext;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  // PC, depth counter and sticky error flags.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc_out        <= RESET_VECTOR;
      stack_depth   <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pc_out      <= pc_next;
      stack_depth <= depth_next;
      if (ovf_set) overflow_err  <= 1'b1;
      if (unf_set) underflow_err <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_en) stack_mem[push_idx] <= pc_inc;
  end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised program counter with a hardware return-address stack; successor to the 16-bit PC of the processor core.
- Adds configurable width, PC-relative branches, call/return with a bounded stack, and sticky stack error flags.
- Sits in the fetch stage. It drives the instruction-memory address and takes control from the decode/branch unit.

Parameters:
- PC_WIDTH, 16, width of the PC and of the return addresses.
- OFFSET_WIDTH, 8, width of the signed relative-branch offset (2's complement); must be <= PC_WIDTH.
- STACK_DEPTH, 8, number of return-address entries (>= 2).
- RESET_VECTOR, 0, PC value after reset.
- TRAP_VECTOR, all-ones (PC_WIDTH bits), error-trap target; used only with PC_TRAP_EN.

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous, active-low reset
- enable  in  1  advance/update the PC this cycle; 0 = stall (hold all state)
- load  in  1  absolute jump to new_pc
- branch  in  1  relative branch: pc_out + sign-extended offset
- call  in  1  push pc_out+1, jump to new_pc
- ret  in  1  pop the top entry into the PC
- new_pc  in  PC_WIDTH  jump/call target
- offset  in  OFFSET_WIDTH  signed branch displacement
- pc_out  out  PC_WIDTH  current PC (registered)
- stack_depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  out  1  stack_depth == STACK_DEPTH (combinational from count)
- stack_empty  out  1  stack_depth == 0
- overflow_err  out  1  sticky: a call was made while the stack was full
- underflow_err  out  1  sticky: a ret was made while the stack was empty

Behaviour:
- Reset (clear_n=0, asynchronous): pc_out=RESET_VECTOR, stack_depth=0, overflow_err=0, underflow_err=0. Stack contents are don't-care. Release is synchronous to clock.
- All updates occur at the rising edge. Latency is 1 cycle: the PC for an op presented in cycle N is visible in cycle N+1.
- enable=0: pc_out, stack and flags hold. All op inputs are ignored.
- enable=1: one op is selected by fixed priority call > ret > load > branch > increment. Lower-priority inputs in the same cycle are ignored.
- increment: pc_out <= pc_out+1.
- load: pc_out <= new_pc.
- branch: pc_out <= pc_out + sign_extend(offset).
- call, not full: stack[depth] <= pc_out+1; depth+1; pc_out <= new_pc.
- call, full: push discarded (stack unchanged); overflow_err <= 1; pc_out <= new_pc (without PC_TRAP_EN).
- ret, not empty: pc_out <= stack[depth-1]; depth-1.
- ret, empty: overflow_err unaffected; underflow_err <= 1; pc_out <= pc_out+1 (without PC_TRAP_EN).
- Arithmetic is modulo 2^PC_WIDTH. All-ones + 1 wraps to 0. Branch results wrap both ways. The pushed return address wraps identically.
- Error flags are sticky: cleared only by clear_n.
- Stack is LIFO. It is implemented as a register array indexed by the depth counter; no internal read latency is allowed.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: a call on a full stack or a ret on an empty stack sets its error flag and forces pc_out <= TRAP_VECTOR. The stack is unchanged.
- Undefined: TRAP_VECTOR is unused and the error behaviour is exactly as listed in Behaviour.

Test Plan:
- Reset/increment: clear_n low mid-run with pc=0x0042 -> pc_out=0x0000 immediately, without a clock edge. Release, enable=1 for 3 cycles -> 0x0001, 0x0002, 0x0003. enable=0 -> holds at 0x0003.
- Branch wrap: pc=0x0002, branch offset=8'hFC (-4) -> pc=0xFFFE. Then branch offset=8'h05 -> pc=0x0003.
- Nested call/ret: at pc=0x0010 call new_pc=0x0100 -> pc=0x0100, depth=1. At 0x0100 call 0x0200 -> depth=2. ret -> 0x0101. ret -> 0x0011, stack_empty=1.
- Overflow: 8 calls fill the stack (stack_full=1). A 9th call to 0x0300 -> pc=0x0300, depth stays 8, overflow_err=1. 8 rets return the original 8 addresses in reverse order.
- Underflow and priority: empty stack, pc=0x0020, ret -> pc=0x0021, underflow_err=1 and stays 1. call+ret+load asserted together with new_pc=0x0400 -> call wins: pc=0x0400, depth=1.
- PC_TRAP_EN build: ret on an empty stack -> pc=0xFFFF, underflow_err=1. Call on a full stack -> pc=0xFFFF, depth unchanged.
